imem_loader: RTL

- Boot-time program loader sitting directly upstream of the single-cycle MIPS core's instruction memory write port.
- Receives a byte stream over a valid/ready handshake: 16-bit word count header, N little-endian instruction words, XOR checksum byte.
- Assembles 32-bit words and issues one write per word to instruction memory.
- Holds the core in reset until the image is loaded and verified.

---
 rtl/imem_loader_if.sv | 39 +++
 rtl/imem_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream and instruction memory write bundle for imem_loader
// Purpose: groups the loader's incoming byte-stream handshake with its
//   outgoing instruction memory write port.
// Signals:
//   byte_in      [7:0]  stream data (source -> loader)
//   byte_valid          byte_in is valid (source -> loader)
//   byte_ready          loader takes byte_in on this edge (loader -> source)
//   WE                  instruction memory write enable (loader -> memory)
//   INSTRUCTIONS [DW]   word to write (loader -> memory)
//   ADDR         [31:0] byte address of the write (loader -> memory)
// Modports: master = stream source / memory side, slave = loader side.
interface imem_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  WE;
  logic [DATA_WIDTH-1:0] INSTRUCTIONS;
  logic [31:0]           ADDR;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  WE,
    input  INSTRUCTIONS,
    input  ADDR
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output WE,
    output INSTRUCTIONS,
    output ADDR
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction memory loader with header and XOR checksum
// Purpose: receives a byte stream (16-bit LE word count, N LE 32-bit words,
//   XOR checksum of the payload bytes), writes each assembled word to
//   instruction memory and keeps the core in reset until the image checks out.
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   start      one-cycle pulse, begins a load from IDLE, DONE or ERROR
//   abort      returns to IDLE from any state, beats start
//   bus        imem_loader_if.slave: byte stream in, memory write out
//   cpu_rst_n  core reset, released only in DONE
//   busy       load in progress
//   done       image loaded and checksum matched
//   error      bad header or checksum mismatch
//   word_cnt   words written so far
module imem_loader #(
  parameter int DATA_WIDTH      = 32,
  parameter int INSTR_MEM_DEPTH = 1024,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 abort,
  imem_loader_if.slave         bus,
  output logic                 cpu_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_PAYLOAD,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [CNT_WIDTH:0] LP_DEPTH = (CNT_WIDTH + 1)'(INSTR_MEM_DEPTH);

  // Registered status flags are loaded together with the state they belong
  // to, so they always match r_state without decoding it combinationally.
  // Packing: {byte_ready, busy, done, error, cpu_rst_n}
  function automatic logic [4:0] flags_of(input state_t s);
    case (s)
      S_HDR_LO, S_HDR_HI,
      S_PAYLOAD, S_CHECK: flags_of = 5'b11000;
      S_WRITE:            flags_of = 5'b01000;
      S_DONE:             flags_of = 5'b00101;
      S_ERROR:            flags_of = 5'b00010;
      default:            flags_of = 5'b00000;
    endcase
  endfunction

  state_t                r_state;
  logic [4:0]            r_flags;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [31:0]           r_addr;
  logic [23:0]           r_word;   // bytes 0..2 of the word; byte 3 goes straight to r_instr
  logic [1:0]            r_k;      // byte position inside the current word
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  r_index;
  logic [7:0]            r_csum;

  logic                  w_accept;
  logic [CNT_WIDTH-1:0]  w_hdr_count;
  logic                  w_hdr_bad;
  logic [CNT_WIDTH-1:0]  w_index_inc;

  assign w_accept    = bus.byte_valid & r_flags[4];
  assign w_hdr_count = {bus.byte_in, r_count[7:0]};
  assign w_hdr_bad   = (w_hdr_count == '0) || ({1'b0, w_hdr_count} > LP_DEPTH);
  assign w_index_inc = r_index + CNT_WIDTH'(1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_flags <= 5'b00000;
      r_we    <= 1'b0;
      r_instr <= '0;
      r_addr  <= '0;
      r_word  <= '0;
      r_k     <= '0;
      r_count <= '0;
      r_index <= '0;
      r_csum  <= '0;
    end else begin
      r_we <= 1'b0;
      if (abort) begin
        // Taking priority here also suppresses the WRITE entry, so no write
        // is issued for an abort that lands on a word's last byte.
        r_state <= S_IDLE;
        r_flags <= flags_of(S_IDLE);
        r_k     <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
              r_state <= S_HDR_LO;
              r_flags <= flags_of(S_HDR_LO);
              r_index <= '0;
              r_csum  <= '0;
              r_k     <= '0;
            end
          end
          S_HDR_LO: begin
            if (w_accept) begin
              r_count[7:0] <= bus.byte_in;
              r_state      <= S_HDR_HI;
            end
          end
          S_HDR_HI: begin
            if (w_accept) begin
              r_count <= w_hdr_count;
              if (w_hdr_bad) begin
                r_state <= S_ERROR;
                r_flags <= flags_of(S_ERROR);
              end else begin
                r_state <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            if (w_accept) begin
              r_csum <= r_csum ^ bus.byte_in;
              r_k    <= r_k + 2'd1;
              case (r_k)
                2'd0: r_word[7:0]   <= bus.byte_in;
                2'd1: r_word[15:8]  <= bus.byte_in;
                2'd2: r_word[23:16] <= bus.byte_in;
                default: begin
                  r_instr <= DATA_WIDTH'({bus.byte_in, r_word});
                  r_addr  <= {{(32 - CNT_WIDTH - 2){1'b0}}, r_index, 2'b00};
                  r_we    <= 1'b1;
                  r_state <= S_WRITE;
                  r_flags <= flags_of(S_WRITE);
                end
              endcase
            end
          end
          S_WRITE: begin
            r_index <= w_index_inc;
            if (w_index_inc == r_count) begin
              r_state <= S_CHECK;
              r_flags <= flags_of(S_CHECK);
            end else begin
              r_state <= S_PAYLOAD;
              r_flags <= flags_of(S_PAYLOAD);
            end
          end
          S_CHECK: begin
            if (w_accept) begin
              if (bus.byte_in == r_csum) begin
                r_state <= S_DONE;
                r_flags <= flags_of(S_DONE);
              end else begin
                r_state <= S_ERROR;
                r_flags <= flags_of(S_ERROR);
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_flags <= flags_of(S_IDLE);
          end
        endcase
      end
    end
  end

  assign bus.byte_ready   = r_flags[4];
  assign busy             = r_flags[3];
  assign done             = r_flags[2];
  assign error            = r_flags[1];
  assign cpu_rst_n        = r_flags[0];
  assign bus.WE           = r_we;
  assign bus.INSTRUCTIONS = r_instr;
  assign bus.ADDR         = r_addr;
  assign word_cnt         = r_index;

endmodule
